// File: rtl/bitmap_pixel_fetch.sv
// rtl/bitmap_pixel_fetch.sv - scanline pixel fetcher between an address stage and VRAM
//
// Walks one scanline column by column. For each column the external address
// stage turns x_out/y_out into a byte address (addr_in). The block reads the
// containing 16-bit halfword from VRAM, or reuses the buffered halfword when an
// 8bpp column falls in the same halfword, and presents the pixel on a
// valid/ready stream.
//
// Ports:
//   clock, reset                      clock and synchronous active-high reset
//   start, line_y, hmax,
//   bitmap_color, frame               line request, latched when start is accepted
//   x_out, y_out, hmax_out,
//   color_out, frame_out, addr_in     address-stage interface
//   vram_req, vram_addr, vram_ack,
//   vram_rdata, vram_rvalid           single-outstanding halfword read port
//   pix_valid, pix_ready, pix_data,
//   pix_is_palette, pix_x             pixel output stream
//   busy, done                        line status

module bitmap_pixel_fetch (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  line_y,
    input  logic [9:0]  hmax,
    input  logic        bitmap_color,
    input  logic        frame,
    output logic [7:0]  x_out,
    output logic [7:0]  y_out,
    output logic [9:0]  hmax_out,
    output logic        color_out,
    output logic        frame_out,
    input  logic [16:0] addr_in,
    output logic        vram_req,
    output logic [15:0] vram_addr,
    input  logic        vram_ack,
    input  logic [15:0] vram_rdata,
    input  logic        vram_rvalid,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [15:0] pix_data,
    output logic        pix_is_palette,
    output logic [7:0]  pix_x,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECIDE,
        S_REQ,
        S_WAIT,
        S_OUT
    } state_t;

    state_t      r_state;
    logic [7:0]  r_x;
    logic [7:0]  r_y;
    logic [9:0]  r_hmax;
    logic        r_color;
    logic        r_frame;
    logic [15:0] r_buf;
    logic [15:0] r_tag;
    logic        r_buf_valid;
    logic        r_bsel;
    logic        r_vram_req;
    logic [15:0] r_vram_addr;
    logic        r_pix_valid;
    logic [15:0] r_pix_data;
    logic        r_pix_pal;
    logic [7:0]  r_pix_x;
    logic        r_done;

    logic [7:0]  w_last;
    logic        w_hit;

    // Lines wider than 256 pixels are clipped at column 255 so x never wraps.
    assign w_last = (r_hmax[9:8] == 2'b00) ? r_hmax[7:0] : 8'hFF;

    // Only 8bpp pixels can share a halfword with their neighbour.
    assign w_hit = r_buf_valid && !r_color && (addr_in[16:1] == r_tag);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_x         <= 8'd0;
            r_y         <= 8'd0;
            r_hmax      <= 10'd0;
            r_color     <= 1'b0;
            r_frame     <= 1'b0;
            r_buf       <= 16'd0;
            r_tag       <= 16'd0;
            r_buf_valid <= 1'b0;
            r_bsel      <= 1'b0;
            r_vram_req  <= 1'b0;
            r_vram_addr <= 16'd0;
            r_pix_valid <= 1'b0;
            r_pix_data  <= 16'd0;
            r_pix_pal   <= 1'b0;
            r_pix_x     <= 8'd0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_y         <= line_y;
                        r_hmax      <= hmax;
                        r_color     <= bitmap_color;
                        r_frame     <= frame;
                        r_x         <= 8'd0;
                        r_buf_valid <= 1'b0;
                        r_state     <= S_DECIDE;
                    end
                end
                S_DECIDE: begin
                    r_bsel <= addr_in[0];
                    if (w_hit) begin
                        r_pix_valid <= 1'b1;
                        r_pix_data  <= {8'h00, addr_in[0] ? r_buf[15:8] : r_buf[7:0]};
                        r_pix_x     <= r_x;
                        r_pix_pal   <= 1'b1;
                        r_state     <= S_OUT;
                    end else begin
                        r_vram_req  <= 1'b1;
                        r_vram_addr <= addr_in[16:1];
                        r_state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (vram_ack) begin
                        r_vram_req <= 1'b0;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // vram_addr still holds the address of the read in flight.
                    if (vram_rvalid) begin
                        r_buf       <= vram_rdata;
                        r_tag       <= r_vram_addr;
                        r_buf_valid <= 1'b1;
                        r_pix_valid <= 1'b1;
                        r_pix_data  <= r_color ? vram_rdata
                                     : {8'h00, r_bsel ? vram_rdata[15:8] : vram_rdata[7:0]};
                        r_pix_x     <= r_x;
                        r_pix_pal   <= ~r_color;
                        r_state     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (pix_ready) begin
                        r_pix_valid <= 1'b0;
                        if (r_x == w_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_x     <= r_x + 8'd1;
                            r_state <= S_DECIDE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign x_out          = r_x;
    assign y_out          = r_y;
    assign hmax_out       = r_hmax;
    assign color_out      = r_color;
    assign frame_out      = r_frame;
    assign vram_req       = r_vram_req;
    assign vram_addr      = r_vram_addr;
    assign pix_valid      = r_pix_valid;
    assign pix_data       = r_pix_data;
    assign pix_is_palette = r_pix_pal;
    assign pix_x          = r_pix_x;
    assign busy           = (r_state != S_IDLE);
    assign done           = r_done;

endmodule

// File: tb/tb_bitmap_pixel_fetch.sv
// tb/tb_bitmap_pixel_fetch.sv - directed self-checking bench for bitmap_pixel_fetch

module tb_bitmap_pixel_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  line_y;
    logic [9:0]  hmax;
    logic        bitmap_color;
    logic        frame;
    logic [7:0]  x_out;
    logic [7:0]  y_out;
    logic [9:0]  hmax_out;
    logic        color_out;
    logic        frame_out;
    logic [16:0] addr_in;
    logic        vram_req;
    logic [15:0] vram_addr;
    logic        vram_ack;
    logic [15:0] vram_rdata;
    logic        vram_rvalid;
    logic        pix_valid;
    logic        pix_ready;
    logic [15:0] pix_data;
    logic        pix_is_palette;
    logic [7:0]  pix_x;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    // memory model knobs and state
    int          ack_delay = 0;
    int          rv_delay  = 2;
    int          req_cnt   = 0;
    int          pend      = 0;
    logic        acked     = 1'b0;
    logic [15:0] pend_addr = 16'd0;

    // logs
    logic [15:0] rd_addr_q[$];
    logic [15:0] px_data_q[$];
    logic [7:0]  px_x_q[$];
    logic        px_pal_q[$];
    int          px_cyc_q[$];
    int          done_cnt     = 0;
    int          valid_cycles = 0;
    int          cyc          = 0;
    int          seen;
    logic [15:0] hold_data;

    bitmap_pixel_fetch dut (
        .clock(clock), .reset(reset), .start(start), .line_y(line_y), .hmax(hmax),
        .bitmap_color(bitmap_color), .frame(frame), .x_out(x_out), .y_out(y_out),
        .hmax_out(hmax_out), .color_out(color_out), .frame_out(frame_out),
        .addr_in(addr_in), .vram_req(vram_req), .vram_addr(vram_addr),
        .vram_ack(vram_ack), .vram_rdata(vram_rdata), .vram_rvalid(vram_rvalid),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_is_palette(pix_is_palette), .pix_x(pix_x), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    // Address stage: 256-byte rows, 2 bytes per pixel at 16bpp, 1 byte at 8bpp.
    always_comb begin
        addr_in = {1'b0, y_out, 8'h00}
                + (color_out ? {8'h00, x_out, 1'b0} : {9'h000, x_out});
    end

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h0180) return 16'hBBAA;
        if (a == 16'h0181) return 16'hDDCC;
        return a ^ 16'h5A5A;
    endfunction

    // VRAM responder: ack after ack_delay cycles of request, rvalid rv_delay cycles after ack.
    initial begin
        vram_ack = 1'b0; vram_rvalid = 1'b0; vram_rdata = 16'd0;
        forever begin
            @(negedge clock);
            vram_ack = 1'b0; vram_rvalid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    vram_rvalid = 1'b1;
                    vram_rdata  = mem_word(pend_addr);
                end
            end
            if (!vram_req) begin
                acked = 1'b0; req_cnt = 0;
            end else if (!acked) begin
                if (req_cnt >= ack_delay) begin
                    vram_ack  = 1'b1;
                    acked     = 1'b1;
                    rd_addr_q.push_back(vram_addr);
                    pend      = rv_delay;
                    pend_addr = vram_addr;
                end else begin
                    req_cnt++;
                end
            end
        end
    end

    // Output monitor.
    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            if (pix_valid) valid_cycles++;
            if (pix_valid && pix_ready) begin
                px_data_q.push_back(pix_data);
                px_x_q.push_back(pix_x);
                px_pal_q.push_back(pix_is_palette);
                px_cyc_q.push_back(cyc);
            end
            if (done) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic clear_logs;
        rd_addr_q.delete(); px_data_q.delete(); px_x_q.delete();
        px_pal_q.delete(); px_cyc_q.delete();
        done_cnt = 0; valid_cycles = 0;
    endtask

    task automatic start_line(input logic [7:0] y, input logic [9:0] hm,
                              input logic col, input logic fr);
        line_y = y; hmax = hm; bitmap_color = col; frame = fr; start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            step(1);
            k++;
        end
        check(tag, done_cnt != 0, 1);
        step(2);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int k = 0;
        while (!pix_valid && k < budget) begin
            step(1);
            k++;
        end
        check(tag, pix_valid, 1'b1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b1; line_y = 8'h77; hmax = 10'd5;
        bitmap_color = 1'b1; frame = 1'b1; pix_ready = 1'b0;
        step(3);
        reset = 1'b0; start = 1'b0;
        step(1);

        // reset state
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_vram_req", vram_req, 0);
        check("rst_vram_addr", vram_addr, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_pix_data", pix_data, 0);
        check("rst_pix_x", pix_x, 0);
        check("rst_pix_pal", pix_is_palette, 0);
        check("rst_x_out", x_out, 0);
        check("rst_y_out", y_out, 0);

        // 16bpp line, four misses
        clear_logs(); ack_delay = 0; rv_delay = 2; pix_ready = 1'b1;
        start_line(8'd2, 10'd3, 1'b1, 1'b0);
        check("t1_busy", busy, 1);
        wait_done("t1_done_timeout", 200);
        check("t1_nreads", rd_addr_q.size(), 4);
        check("t1_npix", px_data_q.size(), 4);
        check("t1_ndone", done_cnt, 1);
        check("t1_busy_after", busy, 0);
        if (rd_addr_q.size() == 4 && px_data_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("t1_raddr%0d", i), rd_addr_q[i], 16'h0100 + 16'(i));
                check($sformatf("t1_px%0d", i), px_x_q[i], i);
                check($sformatf("t1_pd%0d", i), px_data_q[i], (16'h0100 + 16'(i)) ^ 16'h5A5A);
                check($sformatf("t1_pal%0d", i), px_pal_q[i], 0);
            end
        end

        // 8bpp line, halfword reuse
        clear_logs();
        start_line(8'd3, 10'd3, 1'b0, 1'b0);
        wait_done("t2_done_timeout", 200);
        check("t2_nreads", rd_addr_q.size(), 2);
        check("t2_npix", px_data_q.size(), 4);
        if (rd_addr_q.size() == 2 && px_data_q.size() == 4) begin
            check("t2_raddr0", rd_addr_q[0], 16'h0180);
            check("t2_raddr1", rd_addr_q[1], 16'h0181);
            check("t2_pd0", px_data_q[0], 16'h00AA);
            check("t2_pd1", px_data_q[1], 16'h00BB);
            check("t2_pd2", px_data_q[2], 16'h00CC);
            check("t2_pd3", px_data_q[3], 16'h00DD);
            for (int i = 0; i < 4; i++) check($sformatf("t2_pal%0d", i), px_pal_q[i], 1);
            check("t2_hit_gap", px_cyc_q[1] - px_cyc_q[0], 2);
            check("t2_miss_gap", px_cyc_q[2] - px_cyc_q[1], 5);
        end

        // backpressure on pixel 1
        clear_logs(); pix_ready = 1'b0;
        start_line(8'd4, 10'd2, 1'b1, 1'b0);
        for (int p = 0; p < 3; p++) begin
            wait_valid($sformatf("t3_valid_timeout%0d", p), 50);
            if (p == 1) begin
                hold_data = 16'h0201 ^ 16'h5A5A;
                for (int c = 0; c < 5; c++) begin
                    check("t3_hold_valid", pix_valid, 1);
                    check("t3_hold_data", pix_data, hold_data);
                    check("t3_hold_x", pix_x, 1);
                    check("t3_hold_noreq", vram_req, 0);
                    step(1);
                end
            end
            pix_ready = 1'b1;
            step(1);
            pix_ready = 1'b0;
        end
        wait_done("t3_done_timeout", 50);
        check("t3_nreads", rd_addr_q.size(), 3);
        check("t3_npix", px_data_q.size(), 3);
        if (px_data_q.size() == 3) check("t3_pd1", px_data_q[1], 16'h0201 ^ 16'h5A5A);

        // ack stall, single-pixel line
        clear_logs(); pix_ready = 1'b1; ack_delay = 6;
        start_line(8'd5, 10'd0, 1'b1, 1'b0);
        seen = 0;
        while (!vram_req && seen < 20) begin step(1); seen++; end
        for (int c = 0; c < 6; c++) begin
            check("t4_req_held", vram_req, 1);
            check("t4_addr_held", vram_addr, 16'h0280);
            step(1);
        end
        wait_done("t4_done_timeout", 100);
        check("t4_nreads", rd_addr_q.size(), 1);
        check("t4_npix", px_data_q.size(), 1);
        check("t4_ndone", done_cnt, 1);
        if (px_x_q.size() == 1) check("t4_px0", px_x_q[0], 0);
        ack_delay = 0;

        // reset while waiting for read data, then a late rvalid
        clear_logs(); rv_delay = 8;
        start_line(8'd6, 10'd1, 1'b0, 1'b1);
        seen = 0;
        while (rd_addr_q.size() == 0 && seen < 50) begin step(1); seen++; end
        step(2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("t5_busy", busy, 0);
        check("t5_vram_req", vram_req, 0);
        check("t5_vram_addr", vram_addr, 0);
        check("t5_y_out", y_out, 0);
        check("t5_x_out", x_out, 0);
        step(12);
        check("t5_no_valid", valid_cycles, 0);
        check("t5_busy_late", busy, 0);
        check("t5_pix_data", pix_data, 0);
        clear_logs(); rv_delay = 2;
        start_line(8'd3, 10'd1, 1'b0, 1'b0);
        wait_done("t5_done_timeout", 100);
        check("t5_nreads", rd_addr_q.size(), 1);
        check("t5_npix", px_data_q.size(), 2);
        if (px_data_q.size() == 2) begin
            check("t5_pd0", px_data_q[0], 16'h00AA);
            check("t5_pd1", px_data_q[1], 16'h00BB);
        end

        // wide line clipped at 255, start ignored while busy
        clear_logs();
        start_line(8'd1, 10'd300, 1'b1, 1'b1);
        step(20);
        check("t6_busy", busy, 1);
        check("t6_hmax_out", hmax_out, 10'd300);
        check("t6_frame_out", frame_out, 1);
        start_line(8'd9, 10'd2, 1'b0, 1'b0);
        step(2);
        check("t6_y_kept", y_out, 1);
        check("t6_color_kept", color_out, 1);
        wait_done("t6_done_timeout", 4000);
        check("t6_npix", px_data_q.size(), 256);
        check("t6_nreads", rd_addr_q.size(), 256);
        check("t6_ndone", done_cnt, 1);
        check("t6_y_end", y_out, 1);
        if (px_x_q.size() == 256) begin
            check("t6_first_x", px_x_q[0], 0);
            check("t6_last_x", px_x_q[255], 255);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
